i2s_out_gen2: RTL and testbench
===============================

Name: i2s_out_gen2

Overview:
Parametrised second-generation I2S transmitter. It buffers stereo frames from the Filter block in an internal FIFO and serialises them onto i2so_sd/i2so_ws. Compared with the first generation it adds configurable sample width, slot width, FIFO depth, I2S vs left-justified framing, an enable with clean frame-boundary stop, a selectable underrun policy and a FIFO level readout. Sits between the Filter output and the chip's I2S output pins.

Parameters:
SAMPLE_W, 16, bits per channel sample; filt_data carries 2*SAMPLE_W bits.
SLOT_W, 32, sck cycles per channel slot; must be >= SAMPLE_W; the sample is MSB-first and the slot tail is zero-padded.
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW frames.
MODE, 0, framing: 0 = I2S (data lags ws by one sck), 1 = left-justified.
UNDERRUN_HOLD, 0, on underrun: 0 = transmit zero frame, 1 = repeat last transmitted frame.

Ports:
clk  input  1  master clock
rst_n  input  1  asynchronous active-low reset
sck_inp  input  1  serial clock level, already synchronised
sck_transition  input  1  one-clk pulse on each sck falling edge; all serial updates happen on it
enable  input  1  transmit enable; sampled only at frame boundaries
filt_rts  input  1  Filter has a frame ready
filt_rtr  output  1  block can accept a frame
filt_data  input  2*SAMPLE_W  frame; left = upper SAMPLE_W bits, right = lower
i2so_sck  output  1  equals sck_inp (combinational pass-through)
i2so_ws  output  1  word select: 0 = left, 1 = right
i2so_sd  output  1  serial data, MSB first
trig_fifo_underrun  input  1  clears ro_fifo_underrun
ro_fifo_underrun  output  1  sticky underrun flag
ro_fifo_level  output  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW

Behaviour:
- Reset: i2so_ws=0, i2so_sd=0, ro_fifo_underrun=0, FIFO empty, ro_fifo_level=0, filt_rtr=1, state IDLE, bit counter 0, last-frame register 0.
- FIFO write: when filt_rts & filt_rtr. filt_rtr = (level != depth), combinational from the registered count.
- FIFO read: pop only at a frame load. Push and pop in the same cycle leave the level unchanged. A pop never occurs when the FIFO is empty.
- Bit counter b runs 0..2*SLOT_W-1. It advances only on sck_transition and wraps to 0 at a frame load.
- State IDLE:
  - ws=0, sd=0. The FIFO still accepts writes.
  - On sck_transition with enable=1: load a frame, set b=0, go to RUN.
- State RUN:
  - Each sck_transition: if b < 2*SLOT_W-1, then b++.
  - At b = 2*SLOT_W-1: if enable=1, load the next frame and set b=0. Otherwise go to IDLE and drive ws=0, sd=0.
  - A frame always completes once started.
- Frame load:
  - If the FIFO is non-empty, pop it and capture the frame into the last-frame register.
  - If the FIFO is empty, this is an underrun: set ro_fifo_underrun. Send zeros (UNDERRUN_HOLD=0) or the last-frame register (UNDERRUN_HOLD=1).
  - Shift register = {left, zeros(SLOT_W-SAMPLE_W), right, zeros(SLOT_W-SAMPLE_W)}.
- Mode LJ: ws = (b >= SLOT_W); sd = shift-register bit for index b.
- Mode I2S:
  - ws = 1 for b in SLOT_W-1..2*SLOT_W-2, else 0 (ws leads by one bit).
  - sd = bit for index b-1. At b=0, sd is the final bit of the previous frame, or 0 if coming from IDLE.
- Output timing: ws and sd are registered and update in the clk cycle after the sck_transition pulse. No other latency.
- Underrun flag:
  - Sticky.
  - trig_fifo_underrun clears it.
  - If set and clear occur in the same cycle, set wins.
  - No underrun is flagged while in IDLE.
- Reset asserted mid-frame: immediate return to reset values. FIFO contents are discarded.

Decomposition:
- Shared package: MODE_I2S=0, MODE_LJ=1, UNDERRUN_ZERO=0, UNDERRUN_HOLD=1.
- Sub-modules:
  - Existing parametrised fifo, instantiated with width 2*SAMPLE_W and depth 2**FIFO_AW, extended with a level output.
  - New i2s_frame_ser containing the IDLE/RUN FSM, bit counter, shift register and MODE framing.
- The top level holds only the sck pass-through and the underrun flag.

Test Plan:
1. SAMPLE_W=16, SLOT_W=16, MODE=0: push 0xA5A5_3C3C, enable=1, 32 sck pulses -> ws falls/rises one sck before the MSBs; sd = 1010010110100101 then 0011110000111100, each delayed one sck; ro_fifo_underrun=0.
2. SAMPLE_W=16, SLOT_W=24, MODE=1: push 0x8001_FFFF -> left slot sd = 1, fourteen 0s, 1, eight 0s; right slot = sixteen 1s, eight 0s; ws=0 for b 0..23, 1 for b 24..47.
3. FIFO_AW=3, enable=0: push 9 frames back-to-back -> first 8 accepted, ro_fifo_level=8, filt_rtr=0 at the 9th; simultaneous push/pop at level 8 is impossible (rtr=0).
4. Empty FIFO, enable=1, UNDERRUN_HOLD=0 -> at the first load ro_fifo_underrun=1 and sd stays 0. With UNDERRUN_HOLD=1 after frame 0x1234_5678 -> the next frame repeats 0x1234_5678.
5. trig_fifo_underrun pulsed in the same cycle as a new underrun -> flag stays 1. Pulsed alone -> flag 0 on the next clk.
6. Drop enable at b=5 -> the frame finishes through b=2*SLOT_W-1, then ws=sd=0 and level is unchanged. Assert rst_n=0 mid-frame -> all outputs 0 and level 0 immediately.

Source files
------------

// File: rtl/i2s_out_gen2_pkg.sv
// rtl/i2s_out_gen2_pkg.sv - shared constants and state type for the i2s_out_gen2 transmitter
package i2s_out_gen2_pkg;

    // Framing selector values for the MODE parameter
    localparam int MODE_I2S = 0;
    localparam int MODE_LJ  = 1;

    // Underrun policy values for the UNDERRUN_HOLD parameter
    localparam int UNDERRUN_ZERO = 0;
    localparam int UNDERRUN_HOLD = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ser_state_e;

endpackage

// File: rtl/i2s_frame_ser.sv
// rtl/i2s_frame_ser.sv - IDLE/RUN frame serialiser with bit counter, shift register and framing
// Ports:
//   sck_transition : one-clk pulse per sck falling edge; all serial state moves on it
//   enable         : honoured only when a frame boundary is reached
//   fifo_empty/fifo_rdata/fifo_pop : head of the frame FIFO and its pop strobe
//   underrun_evt   : one-clk pulse when a frame load finds the FIFO empty
//   ser_ws/ser_sd  : registered word select and serial data
module i2s_frame_ser
    import i2s_out_gen2_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_W    = 32,
    parameter int MODE      = 0,
    parameter int UR_POLICY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck_transition,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [2*SAMPLE_W-1:0] fifo_rdata,
    output logic                  fifo_pop,
    output logic                  underrun_evt,
    output logic                  ser_ws,
    output logic                  ser_sd
);

    localparam int FRAME_W = 2*SLOT_W;
    localparam int BW      = $clog2(FRAME_W);

    localparam logic [BW-1:0] B_LAST    = BW'(FRAME_W-1);
    localparam logic [BW-1:0] B_LAST_M1 = BW'(FRAME_W-2);
    localparam logic [BW-1:0] B_SLOT    = BW'(SLOT_W);
    localparam logic [BW-1:0] B_SLOT_M1 = BW'(SLOT_W-1);

    ser_state_e               state_q, state_d;
    logic [BW-1:0]            b_q, b_d;
    logic [FRAME_W-1:0]       sreg_q, sreg_d;
    logic [2*SAMPLE_W-1:0]    last_q, last_d;
    logic                     ws_q, ws_d;
    logic                     sd_q, sd_d;
    logic                     load, advance, go_idle;

    // Each sample sits MSB-first at the top of its slot with a zero-padded tail.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [2*SAMPLE_W-1:0] f);
        logic [SLOT_W-1:0] l_slot;
        logic [SLOT_W-1:0] r_slot;
        l_slot = SLOT_W'(f[2*SAMPLE_W-1:SAMPLE_W]) << (SLOT_W-SAMPLE_W);
        r_slot = SLOT_W'(f[SAMPLE_W-1:0]) << (SLOT_W-SAMPLE_W);
        return {l_slot, r_slot};
    endfunction

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        sreg_d  = sreg_q;
        last_d  = last_q;
        ws_d    = ws_q;
        sd_d    = sd_q;
        load    = 1'b0;
        advance = 1'b0;
        go_idle = 1'b0;

        if (sck_transition) begin
            if (state_q == ST_IDLE) begin
                load = enable;
            end else if (b_q == B_LAST) begin
                load    = enable;
                go_idle = !enable;
            end else begin
                advance = 1'b1;
            end
        end

        fifo_pop     = load && !fifo_empty;
        underrun_evt = load && fifo_empty;

        if (load) begin
            if (!fifo_empty) begin
                sreg_d = build_frame(fifo_rdata);
                last_d = fifo_rdata;
            end else if (UR_POLICY == UNDERRUN_HOLD) begin
                sreg_d = build_frame(last_q);
            end else begin
                sreg_d = '0;
            end
            b_d     = '0;
            state_d = ST_RUN;
        end else if (advance) begin
            sreg_d = sreg_q << 1;
            b_d    = b_q + 1'b1;
        end else if (go_idle) begin
            b_d     = '0;
            state_d = ST_IDLE;
        end

        // The MSB of sreg_q is the bit at index b_q, so in I2S mode the bit
        // one position behind the new counter value is the old MSB. Leaving
        // IDLE there is no previous bit, hence 0.
        if (sck_transition) begin
            if (state_d == ST_IDLE) begin
                ws_d = 1'b0;
                sd_d = 1'b0;
            end else if (MODE == MODE_LJ) begin
                ws_d = (b_d >= B_SLOT);
                sd_d = sreg_d[FRAME_W-1];
            end else begin
                ws_d = (b_d >= B_SLOT_M1) && (b_d <= B_LAST_M1);
                sd_d = (state_q == ST_RUN) ? sreg_q[FRAME_W-1] : 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            b_q     <= '0;
            sreg_q  <= '0;
            last_q  <= '0;
            ws_q    <= 1'b0;
            sd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            sreg_q  <= sreg_d;
            last_q  <= last_d;
            ws_q    <= ws_d;
            sd_q    <= sd_d;
        end
    end

    assign ser_ws = ws_q;
    assign ser_sd = sd_q;

endmodule

// File: rtl/i2s_out_gen2_fifo.sv
// rtl/i2s_out_gen2_fifo.sv - show-ahead frame FIFO with occupancy output
// Ports:
//   push/wdata : write a word when not full
//   pop/rdata  : rdata is the head word; pop discards it when not empty
//   level      : occupancy 0..2**AW
//   full/empty : derived from the registered occupancy
module i2s_out_gen2_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2**AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/i2s_out_gen2.sv
// rtl/i2s_out_gen2.sv - parametrised I2S / left-justified transmitter with frame FIFO
// Ports:
//   sck_inp/sck_transition : synchronised serial clock level and its falling-edge pulse
//   enable                 : transmit enable, acted on at frame boundaries
//   filt_rts/filt_rtr/filt_data : frame handshake from the Filter (left in upper half)
//   i2so_sck/i2so_ws/i2so_sd    : I2S output pins
//   trig_fifo_underrun/ro_fifo_underrun : clear strobe and sticky underrun flag
//   ro_fifo_level          : FIFO occupancy
module i2s_out_gen2 #(
    parameter int SAMPLE_W      = 16,
    parameter int SLOT_W        = 32,
    parameter int FIFO_AW       = 3,
    parameter int MODE          = 0,
    parameter int UNDERRUN_HOLD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck_inp,
    input  logic                  sck_transition,
    input  logic                  enable,
    input  logic                  filt_rts,
    output logic                  filt_rtr,
    input  logic [2*SAMPLE_W-1:0] filt_data,
    output logic                  i2so_sck,
    output logic                  i2so_ws,
    output logic                  i2so_sd,
    input  logic                  trig_fifo_underrun,
    output logic                  ro_fifo_underrun,
    output logic [FIFO_AW:0]      ro_fifo_level
);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic [2*SAMPLE_W-1:0] fifo_rdata;
    logic                  underrun_evt;
    logic                  underrun_q, underrun_d;

    assign i2so_sck  = sck_inp;
    assign filt_rtr  = !fifo_full;
    assign fifo_push = filt_rts && filt_rtr;

    i2s_out_gen2_fifo #(
        .WIDTH (2*SAMPLE_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (filt_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (ro_fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    i2s_frame_ser #(
        .SAMPLE_W  (SAMPLE_W),
        .SLOT_W    (SLOT_W),
        .MODE      (MODE),
        .UR_POLICY (UNDERRUN_HOLD)
    ) u_ser (
        .clk            (clk),
        .rst_n          (rst_n),
        .sck_transition (sck_transition),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_rdata     (fifo_rdata),
        .fifo_pop       (fifo_pop),
        .underrun_evt   (underrun_evt),
        .ser_ws         (i2so_ws),
        .ser_sd         (i2so_sd)
    );

    // A new underrun beats a simultaneous clear so no event is ever lost.
    always_comb begin
        underrun_d = underrun_q;
        if (underrun_evt) begin
            underrun_d = 1'b1;
        end else if (trig_fifo_underrun) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign ro_fifo_underrun = underrun_q;

endmodule

// File: tb/tb_i2s_out_gen2.sv
// tb/tb_i2s_out_gen2.sv - self-checking bench for i2s_out_gen2 (I2S/16-bit slot and LJ/24-bit slot instances)
module tb_i2s_out_gen2;

    localparam int P_SLOT [2] = '{16, 24};
    localparam int P_MODE [2] = '{0, 1};
    localparam int P_HOLD [2] = '{0, 1};
    localparam int DEPTH      = 8;

    logic        clk;
    logic        rst_n;
    logic        sck_inp;
    logic        sck_t;
    logic        en   [2];
    logic        rts  [2];
    logic        trig [2];
    logic [31:0] d    [2];
    logic        rtr_o [2];
    logic        sck_o [2];
    logic        ws_o  [2];
    logic        sd_o  [2];
    logic        ur_o  [2];
    logic [3:0]  lvl_o [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_cnt  [2];
    logic [31:0] m_fifo [2][DEPTH];
    bit          m_run  [2];
    int          m_b    [2];
    logic [15:0] m_l    [2];
    logic [15:0] m_r    [2];
    logic [31:0] m_last [2];
    bit          m_prev [2];
    bit          m_ws   [2];
    bit          m_sd   [2];
    bit          m_ur   [2];

    bit          cap_ws [2];
    bit          cap_sd [2];
    bit          pulse_trig;

    i2s_out_gen2 #(.SAMPLE_W(16), .SLOT_W(16), .FIFO_AW(3), .MODE(0), .UNDERRUN_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sck_inp(sck_inp), .sck_transition(sck_t),
        .enable(en[0]), .filt_rts(rts[0]), .filt_rtr(rtr_o[0]), .filt_data(d[0]),
        .i2so_sck(sck_o[0]), .i2so_ws(ws_o[0]), .i2so_sd(sd_o[0]),
        .trig_fifo_underrun(trig[0]), .ro_fifo_underrun(ur_o[0]), .ro_fifo_level(lvl_o[0])
    );

    i2s_out_gen2 #(.SAMPLE_W(16), .SLOT_W(24), .FIFO_AW(3), .MODE(1), .UNDERRUN_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sck_inp(sck_inp), .sck_transition(sck_t),
        .enable(en[1]), .filt_rts(rts[1]), .filt_rtr(rtr_o[1]), .filt_data(d[1]),
        .i2so_sck(sck_o[1]), .i2so_ws(ws_o[1]), .i2so_sd(sd_o[1]),
        .trig_fifo_underrun(trig[1]), .ro_fifo_underrun(ur_o[1]), .ro_fifo_level(lvl_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Bit k (0 = first transmitted) of the current model frame.
    function automatic bit fbit(input int id, input int k);
        logic [15:0] s;
        int j;
        if (k < P_SLOT[id]) begin
            s = m_l[id];
            j = k;
        end else begin
            s = m_r[id];
            j = k - P_SLOT[id];
        end
        return (j < 16) ? s[15-j] : 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_run[i] = 0; m_b[i] = 0; m_l[i] = '0; m_r[i] = '0;
            m_last[i] = '0; m_prev[i] = 0; m_ws[i] = 0; m_sd[i] = 0; m_ur[i] = 0;
        end
    endtask

    // Advance the model by one clk using the inputs about to be sampled.
    task automatic model_step(input int id);
        int          s2;
        bit          push, load, go_idle, ev;
        logic [31:0] f;
        s2      = 2 * P_SLOT[id];
        push    = rts[id] && (m_cnt[id] != DEPTH);
        load    = 0;
        go_idle = 0;
        ev      = 0;
        if (sck_t) begin
            if (!m_run[id]) load = en[id];
            else if (m_b[id] == s2 - 1) begin
                load    = en[id];
                go_idle = !en[id];
            end else m_b[id] = m_b[id] + 1;
        end
        if (load) begin
            m_prev[id] = m_run[id] ? fbit(id, s2 - 1) : 1'b0;
            if (m_cnt[id] > 0) begin
                f = m_fifo[id][0];
                for (int k = 0; k < DEPTH - 1; k++) m_fifo[id][k] = m_fifo[id][k+1];
                m_cnt[id]  = m_cnt[id] - 1;
                m_last[id] = f;
            end else begin
                ev = 1;
                f  = P_HOLD[id] ? m_last[id] : 32'h0;
            end
            m_l[id]   = f[31:16];
            m_r[id]   = f[15:0];
            m_b[id]   = 0;
            m_run[id] = 1;
        end
        if (go_idle) begin
            m_run[id] = 0;
            m_b[id]   = 0;
        end
        if (push) begin
            m_fifo[id][m_cnt[id]] = d[id];
            m_cnt[id] = m_cnt[id] + 1;
        end
        if (ev) m_ur[id] = 1;
        else if (trig[id]) m_ur[id] = 0;
        if (sck_t) begin
            if (!m_run[id]) begin
                m_ws[id] = 0;
                m_sd[id] = 0;
            end else if (P_MODE[id] == 1) begin
                m_ws[id] = (m_b[id] >= P_SLOT[id]);
                m_sd[id] = fbit(id, m_b[id]);
            end else begin
                m_ws[id] = (m_b[id] >= P_SLOT[id] - 1) && (m_b[id] <= s2 - 2);
                m_sd[id] = (m_b[id] == 0) ? m_prev[id] : fbit(id, m_b[id] - 1);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ws[%0d]", i),    ws_o[i],  m_ws[i]);
            chk($sformatf("sd[%0d]", i),    sd_o[i],  m_sd[i]);
            chk($sformatf("level[%0d]", i), lvl_o[i], 64'(m_cnt[i]));
            chk($sformatf("rtr[%0d]", i),   rtr_o[i], (m_cnt[i] != DEPTH));
            chk($sformatf("ur[%0d]", i),    ur_o[i],  m_ur[i]);
            chk($sformatf("sck[%0d]", i),   sck_o[i], sck_inp);
        end
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic sck_pulse();
        sck_t   = 1'b1;
        sck_inp = 1'b0;
        trig[0] = pulse_trig;
        cycle();
        trig[0]    = 1'b0;
        pulse_trig = 1'b0;
        sck_t      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cap_ws[i] = ws_o[i];
            cap_sd[i] = sd_o[i];
        end
        cycle();
        sck_inp = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic clear_inputs();
        sck_t = 1'b0;
        pulse_trig = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; rts[i] = 1'b0; trig[i] = 1'b0; d[i] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic push_frame(input int id, input logic [31:0] f);
        rts[id] = 1'b1;
        d[id]   = f;
        cycle();
        rts[id] = 1'b0;
    endtask

    typedef struct {
        bit          rts;
        bit          en;
        bit          sckt;
        logic [31:0] data;
        int          exp_level;
        bit          exp_rtr;
        bit          exp_ur;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] v32, w32;
    logic [47:0] v48, w48;
    bit          sd_any;
    int          npulse;

    initial begin
        rst_n   = 1'b0;
        sck_inp = 1'b1;
        clear_inputs();
        do_reset();

        // Test 1: I2S, 16-bit slots, one frame then stop.
        push_frame(0, 32'hA5A5_3C3C);
        en[0] = 1'b1;
        for (int k = 0; k < 32; k++) begin
            sck_pulse();
            if (k == 0) en[0] = 1'b0;
            v32[31-k] = cap_sd[0];
            w32[31-k] = cap_ws[0];
        end
        chk("t1_sd_stream", v32, 32'h52D2_9E1E);
        chk("t1_ws_stream", w32, 32'h0001_FFFE);
        chk("t1_underrun", ur_o[0], 1'b0);
        sck_pulse();
        chk("t1_idle_ws", cap_ws[0], 1'b0);
        chk("t1_idle_sd", cap_sd[0], 1'b0);

        // Test 2: left-justified, 24-bit slots.
        push_frame(1, 32'h8001_FFFF);
        en[1] = 1'b1;
        for (int k = 0; k < 48; k++) begin
            sck_pulse();
            if (k == 0) en[1] = 1'b0;
            v48[47-k] = cap_sd[1];
            w48[47-k] = cap_ws[1];
        end
        chk("t2_sd_stream", v48, 48'h8001_00FF_FF00);
        chk("t2_ws_stream", w48, 48'h0000_00FF_FFFF);
        sck_pulse();

        // Test 3: FIFO fill with the transmitter disabled, then one load.
        do_reset();
        for (int i = 0; i < 9; i++)
            vecs[i] = '{1'b1, 1'b0, 1'b0, 32'h1000_0000 + 32'(i), (i < 8) ? i + 1 : 8, (i < 7), 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h0, 7, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h2000_0000, 8, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h3000_0000, 8, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            rts[0] = vecs[i].rts;
            en[0]  = vecs[i].en;
            sck_t  = vecs[i].sckt;
            d[0]   = vecs[i].data;
            cycle();
            chk($sformatf("t3_level_row%0d", i), lvl_o[0], 64'(vecs[i].exp_level));
            chk($sformatf("t3_rtr_row%0d", i),   rtr_o[0], vecs[i].exp_rtr);
            chk($sformatf("t3_ur_row%0d", i),    ur_o[0],  vecs[i].exp_ur);
        end
        clear_inputs();
        for (int g = 0; g < 100 && m_run[0]; g++) sck_pulse();
        chk("t3_drained", m_run[0], 1'b0);

        // Test 4: underrun with zero policy and with hold policy.
        do_reset();
        en[0] = 1'b1;
        sck_pulse();
        chk("t4_ur_zero_set", ur_o[0], 1'b1);
        sd_any = cap_sd[0];
        for (int k = 1; k < 32; k++) begin
            sck_pulse();
            sd_any = sd_any | cap_sd[0];
        end
        chk("t4_sd_zero", sd_any, 1'b0);
        push_frame(1, 32'h1234_5678);
        en[1] = 1'b1;
        for (int k = 0; k < 48; k++) sck_pulse();
        chk("t4_ur_hold_clear", ur_o[1], 1'b0);
        for (int k = 0; k < 48; k++) begin
            sck_pulse();
            v48[47-k] = cap_sd[1];
        end
        chk("t4_hold_repeat", v48, 48'h1234_0056_7800);
        chk("t4_ur_hold_set", ur_o[1], 1'b1);

        // Test 5: clear coinciding with a new underrun, then clear alone.
        for (int g = 0; g < 64 && !(m_run[0] && m_b[0] == 31); g++) sck_pulse();
        chk("t5_align", (m_run[0] && m_b[0] == 31), 1'b1);
        pulse_trig = 1'b1;
        sck_pulse();
        chk("t5_set_wins", ur_o[0], 1'b1);
        en[0] = 1'b0;
        en[1] = 1'b0;
        for (int g = 0; g < 120 && (m_run[0] || m_run[1]); g++) sck_pulse();
        chk("t5_idle", (m_run[0] || m_run[1]), 1'b0);
        trig[0] = 1'b1;
        cycle();
        trig[0] = 1'b0;
        chk("t5_clear", ur_o[0], 1'b0);
        chk("t5_other_kept", ur_o[1], 1'b1);

        // Test 6: enable dropped mid-frame, then reset mid-frame.
        do_reset();
        push_frame(0, 32'h1111_2222);
        push_frame(0, 32'h3333_4444);
        en[0] = 1'b1;
        for (int k = 0; k < 6; k++) sck_pulse();
        en[0] = 1'b0;
        for (int k = 0; k < 26; k++) sck_pulse();
        chk("t6_still_running_level", lvl_o[0], 4'd1);
        sck_pulse();
        chk("t6_stop_ws", cap_ws[0], 1'b0);
        chk("t6_stop_sd", cap_sd[0], 1'b0);
        chk("t6_stop_level", lvl_o[0], 4'd1);
        push_frame(0, 32'h5555_6666);
        en[0] = 1'b1;
        for (int k = 0; k < 8; k++) sck_pulse();
        chk("t6_pre_reset_level", lvl_o[0], 4'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ws", ws_o[0], 1'b0);
        chk("t6_rst_sd", sd_o[0], 1'b0);
        chk("t6_rst_level", lvl_o[0], 4'd0);
        chk("t6_rst_rtr", rtr_o[0], 1'b1);
        chk("t6_rst_ur", ur_o[0], 1'b0);
        @(negedge clk);
        do_reset();

        // Randomised traffic: heavy then sparse producer, random enable/clear.
        for (int phase = 0; phase < 2; phase++) begin
            en[0] = 1'b1;
            en[1] = 1'b1;
            for (int p = 0; p < 500; p++) begin
                npulse = $urandom_range(1, 4);
                for (int c = 0; c <= npulse; c++) begin
                    sck_t   = (c == 0);
                    sck_inp = (c <= npulse / 2) ? 1'b0 : 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        rts[i]  = (phase == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 150) == 0);
                        d[i]    = $urandom;
                        trig[i] = ($urandom_range(0, 19) == 0);
                        if ($urandom_range(0, 199) == 0) en[i] = ~en[i];
                    end
                    cycle();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
